// File: rtl/sd_card_key_debounce.sv
//------------------------------------------------------------------------------
//  Module      : sd_card_key_debounce
//  Description : Key/button debouncer with a two-flop input synchronizer,
//                a STABLE/CHECK debounce FSM, a saturating glitch counter and
//                a small Avalon-MM slave for status, period and glitch count.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sd_card_key_debounce #(
   parameter logic [19:0] PERIOD_RST = 20'd50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        raw_in,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        clean_out,
   output logic        changed
);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        s1_q, s2_q;
   logic [19:0] cnt_q, cnt_d;
   logic        clean_q, clean_d;
   logic        changed_q, changed_d;
   logic [15:0] glitch_cnt_q, glitch_cnt_d;
   logic [19:0] period_q, period_d;
   logic [31:0] rdata_q, rdata_d;
   logic        glitch_inc;

   // Bus write decode
   logic wr_en, period_wr, glitch_clr;
   assign wr_en      = chipselect & ~write_n;
   assign period_wr  = wr_en & (address == 2'd1);
   assign glitch_clr = wr_en & (address == 2'd2);

   // Upper write-data bits have no register behind them
   logic unused_wdata;
   assign unused_wdata = &{1'b0, writedata[31:20]};

   // Two-flop synchronizer for the asynchronous key level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= raw_in;
         s2_q <= s1_q;
      end
   end

   // Debounce next-state logic; in CHECK cnt is always >= 1, so a period
   // of 0 naturally behaves as a period of 1
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      clean_d    = clean_q;
      changed_d  = 1'b0;
      glitch_inc = 1'b0;
      case (state_q)
         ST_STABLE: begin
            if (s2_q != clean_q) begin
               state_d = ST_CHECK;
               cnt_d   = 20'd1;
            end else begin
               cnt_d   = 20'd0;
            end
         end
         ST_CHECK: begin
            if (s2_q == clean_q) begin
               state_d    = ST_STABLE;
               cnt_d      = 20'd0;
               glitch_inc = 1'b1;
            end else if (cnt_q >= period_q) begin
               clean_d   = s2_q;
               changed_d = 1'b1;
               state_d   = ST_STABLE;
               cnt_d     = 20'd0;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = 20'd0;
         end
      endcase
   end

   // Glitch counter (saturating, bus clear wins), period register and read mux
   always_comb begin
      glitch_cnt_d = glitch_cnt_q;
      if (glitch_clr) begin
         glitch_cnt_d = 16'd0;
      end else if (glitch_inc && (glitch_cnt_q != 16'hFFFF)) begin
         glitch_cnt_d = glitch_cnt_q + 16'd1;
      end

      period_d = period_wr ? writedata[19:0] : period_q;

      case (address)
         2'd0:    rdata_d = {30'd0, s2_q, clean_q};
         2'd1:    rdata_d = {12'd0, period_q};
         2'd2:    rdata_d = {16'd0, glitch_cnt_q};
         default: rdata_d = 32'd0;
      endcase
   end

   // State and register update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_STABLE;
         cnt_q        <= 20'd0;
         clean_q      <= 1'b0;
         changed_q    <= 1'b0;
         glitch_cnt_q <= 16'd0;
         period_q     <= PERIOD_RST;
         rdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clean_q      <= clean_d;
         changed_q    <= changed_d;
         glitch_cnt_q <= glitch_cnt_d;
         period_q     <= period_d;
         rdata_q      <= rdata_d;
      end
   end

   assign readdata  = rdata_q;
   assign clean_out = clean_q;
   assign changed   = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_card_key_debounce.sv
//------------------------------------------------------------------------------
//  Module      : tb_sd_card_key_debounce
//  Description : Self-checking bench for sd_card_key_debounce; a behavioural
//                model tracks the run of disagreeing samples and predicts
//                clean_out, changed and readdata every cycle.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sd_card_key_debounce;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        raw_in;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        clean_out;
   logic        changed;

   int n_checks = 0;
   int n_fail   = 0;

   sd_card_key_debounce #(.PERIOD_RST(20'd50000)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw_in     (raw_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .clean_out  (clean_out),
      .changed    (changed)
   );

   always #5 clk = ~clk;

   // Reference model: a change is accepted on the (P+1)-th consecutive
   // clock edge at which the synchronized level disagrees with clean_out
   logic        m_s1, m_s2, m_clean, m_changed;
   int          m_run;
   logic [15:0] m_glitch;
   logic [19:0] m_period;
   logic [31:0] m_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = 1'b0; m_s2 = 1'b0; m_clean = 1'b0; m_changed = 1'b0;
      m_run = 0; m_glitch = 16'd0; m_period = 20'd50000; m_rdata = 32'd0;
   endtask

   task automatic model_edge();
      logic [31:0] rd;
      int          effp;
      if (!reset_n) begin
         model_reset();
         return;
      end
      case (address)
         2'd0:    rd = {30'd0, m_s2, m_clean};
         2'd1:    rd = {12'd0, m_period};
         2'd2:    rd = {16'd0, m_glitch};
         default: rd = 32'd0;
      endcase
      m_changed = 1'b0;
      effp = (m_period == 20'd0) ? 1 : int'(m_period);
      if (m_s2 != m_clean) begin
         if (m_run >= 1 && m_run >= effp) begin
            m_clean   = m_s2;
            m_changed = 1'b1;
            m_run     = 0;
         end else begin
            m_run++;
         end
      end else begin
         if (m_run > 0 && m_glitch != 16'hFFFF) m_glitch++;
         m_run = 0;
      end
      if (chipselect && !write_n) begin
         if (address == 2'd1) m_period = writedata[19:0];
         if (address == 2'd2) m_glitch = 16'd0;
      end
      m_rdata = rd;
      m_s2    = m_s1;
      m_s1    = raw_in;
   endtask

   // One clock: model follows the edge, outputs checked on the falling edge
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("clean_out", {31'd0, clean_out}, {31'd0, m_clean});
      check("changed",   {31'd0, changed},   {31'd0, m_changed});
      check("readdata",  readdata, m_rdata);
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic glitch_pulse();
      raw_in = ~m_clean;
      step();
      raw_in = m_clean;
      repeat (5) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
      $fatal(1);
   end

   initial begin
      int found;
      reset_n = 1'b0; raw_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      address = 2'd0; writedata = 32'd0;
      model_reset();
      #1;
      check("rst_clean",   {31'd0, clean_out}, 32'd0);
      check("rst_changed", {31'd0, changed},   32'd0);
      check("rst_rdata",   readdata,           32'd0);
      repeat (2) step();
      reset_n = 1'b1;
      address = 2'd1;
      step();
      check("period_rst", readdata, 32'd50000);

      // Short pulse with period 4 is rejected and counted
      do_write(2'd1, 32'd4);
      raw_in = 1'b1;
      repeat (2) step();
      raw_in = 1'b0;
      repeat (10) step();
      check("glitch_clean", {31'd0, clean_out}, 32'd0);
      address = 2'd2;
      step();
      check("glitch_one", readdata, 32'd1);
      do_write(2'd2, 32'd0);

      // Held step with period 4: update six edges after the first sample
      raw_in = 1'b1;
      repeat (6) step();
      check("p4_before", {31'd0, clean_out}, 32'd0);
      step();
      check("p4_clean",   {31'd0, clean_out}, 32'd1);
      check("p4_changed", {31'd0, changed},   32'd1);
      step();
      check("p4_chg_off", {31'd0, changed},   32'd0);

      // Period 0 behaves as 1
      do_write(2'd1, 32'd0);
      repeat (4) step();
      raw_in = 1'b0;
      repeat (3) step();
      check("p0_before", {31'd0, clean_out}, 32'd1);
      step();
      check("p0_clean", {31'd0, clean_out}, 32'd0);

      // Shrinking the period below the running count completes at once
      do_write(2'd1, 32'd100);
      repeat (4) step();
      raw_in = 1'b1;
      repeat (52) step();
      do_write(2'd1, 32'd3);
      check("shrink_before", {31'd0, clean_out}, 32'd0);
      step();
      check("shrink_clean", {31'd0, clean_out}, 32'd1);

      // Saturation: preload near the top, then glitch past it
      do_write(2'd1, 32'd4);
      repeat (4) step();
      address = 2'd2;
      force dut.glitch_cnt_q = 16'hFFFD;
      m_glitch = 16'hFFFD;
      step();
      release dut.glitch_cnt_q;
      repeat (3) glitch_pulse();
      step();
      check("glitch_sat", readdata, 32'h0000FFFF);

      // Clear write on the same edge as a rejection wins
      raw_in = 1'b0;
      step();
      raw_in = 1'b1;
      repeat (2) step();
      do_write(2'd2, 32'd0);
      address = 2'd2;
      step();
      check("glitch_clr_wins", readdata, 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) raw_in = ~raw_in;
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 7) == 0);
         write_n    = ($urandom_range(0, 1) == 0);
         writedata  = {12'($urandom), 20'($urandom_range(0, 6))};
         step();
      end
      chipselect = 1'b0; write_n = 1'b1;

      // Reset in the middle of a check, then a full-length debounce
      do_write(2'd1, 32'd1);
      raw_in = 1'b0;
      repeat (10) step();
      do_write(2'd1, 32'd100);
      raw_in = 1'b1;
      repeat (20) step();
      reset_n = 1'b0;
      model_reset();
      #1;
      check("midrst_clean", {31'd0, clean_out}, 32'd0);
      check("midrst_rdata", readdata,           32'd0);
      repeat (2) step();
      reset_n = 1'b1;
      address = 2'd1;
      found = 0;
      for (int i = 1; i <= 50100 && found == 0; i++) begin
         step();
         if (i == 1) check("period_after_rst", readdata, 32'd50000);
         if (clean_out) found = i;
      end
      check("rise_edge", 32'(found), 32'd50003);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
